// File: rtl/nios_oci_dct_pkg.sv
// Shared types and sizes for the OCI direct-branch trace packer.
// Frame layout: entry i at bits [2i+1:2i], entry 0 is the oldest code.
package nios_oci_dct_pkg;

  localparam int ENTRY_W = 2;
  localparam int ENTRIES = 15;
  localparam int BUF_W   = ENTRY_W * ENTRIES;
  localparam int CNT_W   = 4;
  localparam int OVF_W   = 8;

  typedef enum logic [ENTRY_W-1:0] {
    DCT_PAD = 2'b00,
    DCT_NT  = 2'b01,
    DCT_TK  = 2'b10,
    DCT_EXC = 2'b11
  } dct_code_t;

  typedef struct packed {
    logic [BUF_W-1:0] data;
    logic [CNT_W-1:0] count;
  } dct_frame_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Writes one code into its slot; every other slot keeps its value.
  function automatic logic [BUF_W-1:0] dct_slot_insert(
    input logic [BUF_W-1:0]   data,
    input logic [CNT_W-1:0]   slot,
    input logic [ENTRY_W-1:0] code
  );
    logic [BUF_W-1:0] result;
    result = data;
    for (int i = 0; i < ENTRIES; i++) begin
      if (slot == CNT_W'(i)) begin
        result[i*ENTRY_W +: ENTRY_W] = code;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/nios_oci_dct_outreg.sv
// One-entry valid/ready holding register for closed trace frames.
// A frame arriving while the held one is not being taken is dropped and counted.
module nios_oci_dct_outreg
  import nios_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  dct_frame_t       load_frame,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             overflow,
  output logic [OVF_W-1:0] ovf_count
);

  out_state_t state;

  assign out_valid = (state == OUT_FULL);

  // A handshake frees the register in the same cycle, so a simultaneous load is never a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= OUT_EMPTY;
      dct_buffer <= '0;
      dct_count  <= '0;
      overflow   <= 1'b0;
      ovf_count  <= '0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (load) begin
            state      <= OUT_FULL;
            dct_buffer <= load_frame.data;
            dct_count  <= load_frame.count;
          end
        end
        OUT_FULL: begin
          if (out_ready) begin
            if (load) begin
              dct_buffer <= load_frame.data;
              dct_count  <= load_frame.count;
            end else begin
              state      <= OUT_EMPTY;
              dct_buffer <= '0;
              dct_count  <= '0;
            end
          end else if (load) begin
            overflow <= 1'b1;
            if (ovf_count != '1) begin
              ovf_count <= ovf_count + 1'b1;
            end
          end
        end
        default: begin
          state <= OUT_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/nios_oci_dct_packer.sv
// Packs 2-bit direct-branch codes into 15-entry trace frames and hands them to
// the output register; trace never back-pressures the CPU.
module nios_oci_dct_packer
  import nios_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               trc_on,
  input  logic               dct_valid,
  input  logic [ENTRY_W-1:0] dct_code,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               overflow,
  output logic [OVF_W-1:0]   ovf_count
);

  logic [BUF_W-1:0] acc_data;
  logic [BUF_W-1:0] next_data;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             trc_on_q;
  logic             accept;
  logic             close;
  dct_frame_t       close_frame;

  assign accept    = trc_on && dct_valid;
  assign next_data = accept ? dct_slot_insert(acc_data, acc_cnt, dct_code) : acc_data;
  assign next_cnt  = acc_cnt + CNT_W'(accept);

  // The close decision looks at the accumulator after this cycle's write, so a code
  // arriving with flush is part of the frame it closes.
  always_comb begin
    close = 1'b0;
    if (trc_on) begin
      close = (next_cnt == CNT_W'(ENTRIES)) || (flush && (next_cnt != '0));
    end else begin
      close = trc_on_q && (acc_cnt != '0);
    end
  end

  assign close_frame = '{data: next_data, count: next_cnt};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_data <= '0;
      acc_cnt  <= '0;
      trc_on_q <= 1'b0;
    end else begin
      trc_on_q <= trc_on;
      if (close) begin
        acc_data <= '0;
        acc_cnt  <= '0;
      end else begin
        acc_data <= next_data;
        acc_cnt  <= next_cnt;
      end
    end
  end

  nios_oci_dct_outreg u_outreg (
    .clk        (clk),
    .reset      (reset),
    .load       (close),
    .load_frame (close_frame),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow),
    .ovf_count  (ovf_count)
  );

endmodule

// File: tb/tb_nios_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: stimulus pushes hand-computed frames,
// a monitor pops and compares every frame the DUT hands over.
module tb_nios_oci_dct_packer;
  import nios_oci_dct_pkg::*;

  logic               clk;
  logic               reset;
  logic               trc_on;
  logic               dct_valid;
  logic [ENTRY_W-1:0] dct_code;
  logic               flush;
  logic               out_ready;
  logic               out_valid;
  logic [BUF_W-1:0]   dct_buffer;
  logic [CNT_W-1:0]   dct_count;
  logic               overflow;
  logic [OVF_W-1:0]   ovf_count;

  dct_frame_t sb[$];
  int         checks = 0;
  int         errors = 0;

  nios_oci_dct_packer dut (
    .clk        (clk),
    .reset      (reset),
    .trc_on     (trc_on),
    .dct_valid  (dct_valid),
    .dct_code   (dct_code),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; returns just after the edge so outputs reflect it.
  task automatic applyStimulus(input logic on, input logic valid, input logic [1:0] code, input logic fl);
    trc_on    = on;
    dct_valid = valid;
    dct_code  = code;
    flush     = fl;
    @(posedge clk);
    #1;
    dct_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic expectFrame(input logic [BUF_W-1:0] data, input logic [CNT_W-1:0] count);
    dct_frame_t f;
    f.data  = data;
    f.count = count;
    sb.push_back(f);
  endtask

  task automatic doReset();
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset dct_buffer", 32'(dct_buffer), 32'd0);
    checkOutput("reset dct_count", 32'(dct_count), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset ovf_count", 32'(ovf_count), 32'd0);
    reset = 1'b0;
  endtask

  // Monitor: every accepted frame must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected frame", 32'(dct_count), 32'd0);
      end else begin
        dct_frame_t exp_f;
        exp_f = sb.pop_front();
        checkOutput("frame data", 32'(dct_buffer), 32'(exp_f.data));
        checkOutput("frame count", 32'(dct_count), 32'(exp_f.count));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    trc_on    = 1'b0;
    dct_valid = 1'b0;
    dct_code  = 2'b00;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    doReset();

    // 1: full frame of alternating codes, oldest first 01
    expectFrame(30'h19999999, 4'd15);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
    checkOutput("t1 out_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);

    // 2: partial frame via flush, then flush on empty accumulator
    expectFrame(30'h0000003A, 4'd3);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("t2 empty flush", 32'(out_valid), 32'd0);

    // 3: frame A held, frame B dropped
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    checkOutput("t3 held data", 32'(dct_buffer), 32'h2AAAAAAA);
    checkOutput("t3 held count", 32'(dct_count), 32'd15);
    checkOutput("t3 overflow", 32'(overflow), 32'd1);
    checkOutput("t3 ovf_count", 32'(ovf_count), 32'd1);
    expectFrame(30'h2AAAAAAA, 4'd15);
    out_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("t3 drained", 32'(out_valid), 32'd0);
    checkOutput("t3 zeroed", 32'(dct_buffer), 32'd0);

    // 4: code with flush joins the closed frame; next code starts a new one
    expectFrame(30'h00000025, 4'd3);
    expectFrame(30'h00000003, 4'd1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);

    // 5: trc_on falling closes the frame; codes while off are ignored
    expectFrame(30'h00000155, 4'd5);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("t5 off ignored", 32'(out_valid), 32'd0);

    // 6: reset with a held frame and 7 pending codes
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    checkOutput("t6 held before reset", 32'(out_valid), 32'd1);
    doReset();
    out_ready = 1'b1;
    expectFrame(30'h00000007, 4'd2);
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
